// File: rtl/flash_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_rd_pkg
// Description : Shared types and constants for the flash read responder.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_rd_pkg;

  // Responder FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DATA = 3'd2,
    RESPOND   = 3'd3,
    RELEASE   = 3'd4
  } rd_state_t;

  // Single-word Avalon reads always fetch all four bytes
  localparam logic [3:0] FLASH_BE_ALL    = 4'b1111;
  localparam logic [5:0] FLASH_BURST_ONE = 6'd1;

endpackage
`default_nettype wire

// File: rtl/flash_read_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : flash_read_responder_if
// Description : Requester handshake plus Avalon-MM flash read port.
//               "slave" is the responder's view, "master" the environment's.
// Revision    : 1.0 - initial release
// ============================================================================
interface flash_read_responder_if #(
  parameter int ADDR_W = 23
);
  // requester side
  logic              req;
  logic [23:0]       word_addr;
  logic              done_signal;
  logic [31:0]       rd_data;
  logic              rd_error;
  // Avalon-MM side
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic [5:0]        flash_mem_burstcount;
  logic              flash_mem_waitrequest;
  logic              flash_mem_readdatavalid;
  logic [31:0]       flash_mem_readdata;

  modport slave (
    input  req, word_addr,
    output done_signal, rd_data, rd_error,
    output flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    input  flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata
  );

  modport master (
    output req, word_addr,
    input  done_signal, rd_data, rd_error,
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    output flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata
  );
endinterface
`default_nettype wire

// File: rtl/flash_hit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : flash_hit_buffer
// Description : One-word cache of the last successfully read flash word.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_hit_buffer #(
  parameter int ADDR_W = 23
) (
  input  logic              clk50M,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_invalidate,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [31:0]       i_load_data,
  input  logic [ADDR_W-1:0] i_cmp_addr,
  output logic              o_hit,
  output logic [31:0]       o_hit_data
);
  logic              r_hit_valid;
  logic [ADDR_W-1:0] r_hit_addr;
  logic [31:0]       r_hit_data;

  // Capture fresh flash data; a load wins over an invalidate in the same cycle
  always_ff @(posedge clk50M) begin
    if (reset) begin
      r_hit_valid <= 1'b0;
      r_hit_addr  <= '0;
      r_hit_data  <= '0;
    end else if (i_load) begin
      r_hit_valid <= 1'b1;
      r_hit_addr  <= i_load_addr;
      r_hit_data  <= i_load_data;
    end else if (i_invalidate) begin
      r_hit_valid <= 1'b0;
    end
  end

  // Compare only the ADDR_W-bit flash address
  always_comb begin
    o_hit      = r_hit_valid && (i_cmp_addr == r_hit_addr);
    o_hit_data = r_hit_data;
  end
endmodule
`default_nettype wire

// File: rtl/flash_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : flash_read_responder
// Description : Serves level-held word read requests from a one-word hit
//               buffer or by single-word Avalon-MM flash reads, with a read
//               timeout that answers with an error instead of hanging.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_read_responder
  import flash_rd_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic                  clk50M,
  input  logic                  reset,
  flash_read_responder_if.slave bus
);
  localparam logic [TO_W-1:0] c_to_limit = TO_W'(TIMEOUT_CYCLES);

  rd_state_t         r_state;
  rd_state_t         w_next_state;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_lookup;    // request address captured, hit check pending
  logic              r_stale;     // a timed-out read may still return data
  logic              r_err_pend;
  logic [TO_W-1:0]   r_to_cnt;
  logic [31:0]       r_rd_data;
  logic              w_to_expired;
  logic              w_hit;
  logic [31:0]       w_hit_data;
  logic              w_load;
  logic              w_invalidate;

  // Upper requester address bits are deliberately not used
  wire w_unused_addr = &{1'b0, bus.word_addr};

  assign w_to_expired = (r_to_cnt == c_to_limit);
  assign w_load       = (r_state == WAIT_DATA) && bus.flash_mem_readdatavalid;
  assign w_invalidate = (r_state == WAIT_DATA) && !bus.flash_mem_readdatavalid && w_to_expired;

  flash_hit_buffer #(
    .ADDR_W (ADDR_W)
  ) u_hit_buf (
    .clk50M       (clk50M),
    .reset        (reset),
    .i_load       (w_load),
    .i_invalidate (w_invalidate),
    .i_load_addr  (r_addr_q),
    .i_load_data  (bus.flash_mem_readdata),
    .i_cmp_addr   (r_addr_q),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );

  // State register
  always_ff @(posedge clk50M) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; a stale read blocks new issues until it drains or ages out
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_lookup) begin
          if (w_hit)                          w_next_state = RESPOND;
          else if (!r_stale || w_to_expired)  w_next_state = ISSUE;
        end
      end
      ISSUE:     if (!bus.flash_mem_waitrequest) w_next_state = WAIT_DATA;
      WAIT_DATA: if (bus.flash_mem_readdatavalid || w_to_expired) w_next_state = RESPOND;
      RESPOND:   w_next_state = RELEASE;
      RELEASE:   if (!bus.req) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Address capture, response data, timeout counter and stale tracking
  always_ff @(posedge clk50M) begin
    if (reset) begin
      r_addr_q   <= '0;
      r_lookup   <= 1'b0;
      r_stale    <= 1'b0;
      r_err_pend <= 1'b0;
      r_to_cnt   <= '0;
      r_rd_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req && !r_lookup) begin
            r_addr_q <= bus.word_addr[ADDR_W-1:0];
            r_lookup <= 1'b1;
          end
          if (r_lookup && w_next_state != IDLE) r_lookup <= 1'b0;
          if (r_lookup && w_hit) r_rd_data <= w_hit_data;
        end
        ISSUE: begin
          if (!bus.flash_mem_waitrequest) r_to_cnt <= '0;
        end
        WAIT_DATA: begin
          if (bus.flash_mem_readdatavalid) begin
            r_rd_data <= bus.flash_mem_readdata;
          end else if (w_to_expired) begin
            r_rd_data  <= '0;
            r_err_pend <= 1'b1;
            r_stale    <= 1'b1;
            r_to_cnt   <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        RESPOND: r_err_pend <= 1'b0;
        default: ;
      endcase

      // Late data after a timeout is dropped; give up on it after another timeout period
      if (r_stale && r_state != ISSUE && r_state != WAIT_DATA) begin
        if (bus.flash_mem_readdatavalid || (r_state == IDLE && r_lookup && w_to_expired))
          r_stale <= 1'b0;
        if (!w_to_expired)
          r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    bus.done_signal          = (r_state == RESPOND);
    bus.rd_error             = (r_state == RESPOND) && r_err_pend;
    bus.rd_data              = r_rd_data;
    bus.flash_mem_read       = (r_state == ISSUE);
    bus.flash_mem_address    = r_addr_q;
    bus.flash_mem_byteenable = FLASH_BE_ALL;
    bus.flash_mem_burstcount = FLASH_BURST_ONE;
  end
endmodule
`default_nettype wire

// File: tb/tb_flash_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_read_responder
// Description : Self-checking bench: Avalon slave model with configurable
//               stall/latency/drop, requester tasks and a hit-buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_read_responder;
  localparam int ADDR_W = 23;
  localparam int TMO    = 15;
  localparam int TO_W   = 4;

  logic clk50M = 1'b0;
  logic reset  = 1'b1;
  always #10 clk50M = ~clk50M;

  flash_read_responder_if #(.ADDR_W(ADDR_W)) bus ();

  flash_read_responder #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (TO_W)
  ) dut (
    .clk50M (clk50M),
    .reset  (reset),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  // Avalon slave controls and observations
  int                cfg_stall = 0;
  int                cfg_lat   = 1;
  bit                cfg_drop  = 0;
  bit                inj_req   = 0;
  logic [31:0]       inj_data  = '0;
  int                cmd_count = 0;
  int                last_accept_cyc = 0;
  logic [ADDR_W-1:0] rd_addr_log[$];
  logic [31:0]       mem_ovr[int];

  // Reference hit-buffer model
  bit                model_valid = 0;
  logic [ADDR_W-1:0] model_addr  = '0;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    h = {9'd0, a} * 32'h9E3779B1;
    return h ^ 32'h13572468;
  endfunction

  // Avalon slave: drives at negedge for the following posedge
  initial begin : avalon_slave
    int stall_left;
    int lat_left;
    bit busy;
    logic [31:0] pend;
    stall_left = 0; lat_left = 0; busy = 0; pend = '0;
    bus.flash_mem_waitrequest   = 1'b1;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata      = '0;
    forever begin
      @(negedge clk50M);
      bus.flash_mem_readdatavalid = 1'b0;
      if (reset) begin
        busy = 0;
        stall_left = cfg_stall;
        bus.flash_mem_waitrequest = 1'b1;
      end else begin
        if (busy) begin
          if (lat_left == 0) begin
            bus.flash_mem_readdatavalid = 1'b1;
            bus.flash_mem_readdata      = pend;
            busy = 0;
          end else lat_left--;
        end else if (inj_req) begin
          bus.flash_mem_readdatavalid = 1'b1;
          bus.flash_mem_readdata      = inj_data;
          inj_req = 0;
        end
        if (bus.flash_mem_read) begin
          rd_addr_log.push_back(bus.flash_mem_address);
          if (stall_left > 0) begin
            bus.flash_mem_waitrequest = 1'b1;
            stall_left--;
          end else begin
            bus.flash_mem_waitrequest = 1'b0;
            cmd_count++;
            last_accept_cyc = cyc + 1;
            stall_left = cfg_stall;
            if (!cfg_drop) begin
              busy = 1;
              lat_left = cfg_lat - 1;
              pend = mem_word(bus.flash_mem_address);
            end
          end
        end else begin
          bus.flash_mem_waitrequest = 1'b1;
          stall_left = cfg_stall;
        end
      end
    end
  end

  // Requester: raise req, wait for done, hold req 'hold' cycles, then drop it
  task automatic do_req(input logic [23:0] a, input int hold,
                        output bit got, output logic [31:0] d, output bit e,
                        output int lat, output int done_cyc, output int extra_done);
    got = 0; d = '0; e = 0; lat = 0; done_cyc = 0; extra_done = 0;
    @(negedge clk50M);
    bus.req = 1'b1;
    bus.word_addr = a;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk50M);
      if (i == 1) bus.word_addr = 24'($urandom);
      if (bus.done_signal) begin
        got = 1; d = bus.rd_data; e = bus.rd_error; lat = i; done_cyc = cyc;
      end
    end
    if (got) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk50M);
        if (bus.done_signal) extra_done++;
      end
    end
    bus.req = 1'b0;
    @(negedge clk50M);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req = 1'b0; bus.word_addr = '0;
    repeat (3) @(negedge clk50M);
    n_tests++; if (bus.done_signal !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done_signal); end
    n_tests++; if (bus.rd_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.rd_error); end
    n_tests++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.rd_data); end
    n_tests++; if (bus.flash_mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", bus.flash_mem_read); end
    n_tests++; if (bus.flash_mem_address !== 23'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.flash_mem_address); end
    reset = 1'b0;
    @(negedge clk50M);
    n_tests++; if (bus.flash_mem_byteenable !== 4'b1111) begin n_fail++; $display("FAIL byteenable: got %b expected 1111", bus.flash_mem_byteenable); end
    n_tests++; if (bus.flash_mem_burstcount !== 6'd1) begin n_fail++; $display("FAIL burstcount: got %0d expected 1", bus.flash_mem_burstcount); end
    model_valid = 0;
  endtask

  task automatic test_miss();
    bit got, e; logic [31:0] d; int lat, dc, xd, c0, bad;
    mem_ovr[32'h100] = 32'hA1B2C3D4;
    cfg_stall = 3; cfg_lat = 4; cfg_drop = 0;
    c0 = cmd_count; rd_addr_log.delete();
    do_req(24'h000100, 0, got, d, e, lat, dc, xd);
    n_tests++; if (!got) begin n_fail++; $display("FAIL miss_done: got none expected one done"); end
    n_tests++; if (d !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL miss_data: got %h expected a1b2c3d4", d); end
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL miss_err: got %b expected 0", e); end
    n_tests++; if (cmd_count - c0 != 1) begin n_fail++; $display("FAIL miss_cmds: got %0d expected 1", cmd_count - c0); end
    n_tests++; if (rd_addr_log.size() != 4) begin n_fail++; $display("FAIL miss_stall_cycles: got %0d expected 4", rd_addr_log.size()); end
    bad = 0;
    foreach (rd_addr_log[k]) if (rd_addr_log[k] !== 23'h000100) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL miss_addr_held: got %0d wrong-address cycles expected 0", bad); end
    model_valid = 1; model_addr = 23'h000100;
  endtask

  task automatic test_hit();
    bit got, e; logic [31:0] d; int lat, dc, xd, c0;
    c0 = cmd_count; rd_addr_log.delete();
    do_req(24'h000100, 0, got, d, e, lat, dc, xd);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL hit_latency: got %0d expected 2", lat); end
    n_tests++; if (d !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL hit_data: got %h expected a1b2c3d4", d); end
    n_tests++; if (rd_addr_log.size() != 0 || cmd_count != c0) begin n_fail++; $display("FAIL hit_no_traffic: got %0d read cycles expected 0", rd_addr_log.size()); end
    // upper requester address bit must not cause a miss
    c0 = cmd_count;
    do_req(24'h800100, 0, got, d, e, lat, dc, xd);
    n_tests++; if (cmd_count != c0 || d !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL hit_upper_bits: got cmds %0d data %h expected 0 a1b2c3d4", cmd_count - c0, d); end
  endtask

  task automatic test_held_req();
    bit got, e; logic [31:0] d; int lat, dc, xd, c0;
    cfg_stall = 1; cfg_lat = 2;
    c0 = cmd_count;
    do_req(24'h000300, 5, got, d, e, lat, dc, xd);
    n_tests++; if (xd != 0) begin n_fail++; $display("FAIL held_extra_done: got %0d expected 0", xd); end
    n_tests++; if (cmd_count - c0 != 1) begin n_fail++; $display("FAIL held_cmds: got %0d expected 1", cmd_count - c0); end
    n_tests++; if (d !== mem_word(23'h000300)) begin n_fail++; $display("FAIL held_data: got %h expected %h", d, mem_word(23'h000300)); end
    c0 = cmd_count;
    do_req(24'h000301, 0, got, d, e, lat, dc, xd);
    n_tests++; if (!got || d !== mem_word(23'h000301) || cmd_count - c0 != 1) begin n_fail++; $display("FAIL held_next_req: got done %b data %h cmds %0d expected 1 %h 1", got, d, cmd_count - c0, mem_word(23'h000301)); end
    model_valid = 1; model_addr = 23'h000301;
  endtask

  task automatic test_timeout();
    bit got, e; logic [31:0] d; int lat, dc, xd, c0;
    cfg_drop = 1;
    c0 = cmd_count;
    do_req(24'h000400, 0, got, d, e, lat, dc, xd);
    cfg_drop = 0;
    model_valid = 0;
    n_tests++; if (!got || e !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got done %b err %b expected 1 1", got, e); end
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL timeout_data: got %h expected 0", d); end
    n_tests++; if (dc - last_accept_cyc != TMO + 1) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", dc - last_accept_cyc, TMO + 1); end
    n_tests++; if (cmd_count - c0 != 1) begin n_fail++; $display("FAIL timeout_cmds: got %0d expected 1", cmd_count - c0); end
    inj_data = 32'hDEADBEEF; inj_req = 1;
    repeat (3) @(negedge clk50M);
    c0 = cmd_count;
    do_req(24'h000400, 0, got, d, e, lat, dc, xd);
    n_tests++; if (cmd_count - c0 != 1) begin n_fail++; $display("FAIL timeout_reissue: got %0d cmds expected 1", cmd_count - c0); end
    n_tests++; if (d !== mem_word(23'h000400) || e !== 1'b0) begin n_fail++; $display("FAIL timeout_late_discard: got %h err %b expected %h 0", d, e, mem_word(23'h000400)); end
    model_valid = 1; model_addr = 23'h000400;
  endtask

  task automatic test_reset_mid_read();
    bit got, e, seen; logic [31:0] d; int lat, dc, xd, c0, dones;
    cfg_stall = 0; cfg_lat = 3;
    do_req(24'h000500, 0, got, d, e, lat, dc, xd);
    cfg_drop = 1;
    c0 = cmd_count; seen = 0;
    @(negedge clk50M);
    bus.req = 1'b1; bus.word_addr = 24'h000510;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk50M);
      if (cmd_count != c0) seen = 1;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rst_mid_issue: got no command expected one"); end
    repeat (3) @(negedge clk50M);
    reset = 1'b1; bus.req = 1'b0;
    @(negedge clk50M);
    reset = 1'b0;
    n_tests++; if ({bus.done_signal, bus.rd_error, bus.flash_mem_read} !== 3'b000 || bus.rd_data !== 32'd0 || bus.flash_mem_address !== 23'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got done %b err %b read %b data %h addr %h expected all 0", bus.done_signal, bus.rd_error, bus.flash_mem_read, bus.rd_data, bus.flash_mem_address);
    end
    dones = 0;
    repeat (25) begin @(negedge clk50M); if (bus.done_signal) dones++; end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected 0", dones); end
    cfg_drop = 0; model_valid = 0;
    c0 = cmd_count;
    do_req(24'h000500, 0, got, d, e, lat, dc, xd);
    n_tests++; if (cmd_count - c0 != 1 || d !== mem_word(23'h000500)) begin n_fail++; $display("FAIL rst_mid_reread: got cmds %0d data %h expected 1 %h", cmd_count - c0, d, mem_word(23'h000500)); end
    model_valid = 1; model_addr = 23'h000500;
  endtask

  task automatic test_sequential();
    bit got, e; logic [31:0] d; int lat, dc, xd, c0, dones;
    logic [23:0] a;
    cfg_stall = 1; cfg_lat = 2;
    c0 = cmd_count; dones = 0;
    for (int i = 0; i < 8; i++) begin
      a = 24'h000200 + 24'(i);
      do_req(a, 1, got, d, e, lat, dc, xd);
      if (got) dones++;
      n_tests++; if (d !== mem_word(a[ADDR_W-1:0])) begin n_fail++; $display("FAIL seq_data[%0d]: got %h expected %h", i, d, mem_word(a[ADDR_W-1:0])); end
    end
    n_tests++; if (cmd_count - c0 != 8 || dones != 8) begin n_fail++; $display("FAIL seq_counts: got cmds %0d dones %0d expected 8 8", cmd_count - c0, dones); end
    model_valid = 1; model_addr = 23'h000207;
  endtask

  task automatic test_random();
    bit got, e, exp_hit, b; logic [31:0] d; int lat, dc, xd, c0;
    logic [23:0] a;
    for (int i = 0; i < 24; i++) begin
      a = 24'h000600 + 24'($urandom_range(0, 3));
      b = 1'($urandom_range(0, 1));
      a[23] = b;
      cfg_stall = $urandom_range(0, 3);
      cfg_lat = $urandom_range(1, 8);
      exp_hit = model_valid && (a[ADDR_W-1:0] == model_addr);
      c0 = cmd_count;
      do_req(a, $urandom_range(0, 3), got, d, e, lat, dc, xd);
      n_tests++;
      if (!got || e !== 1'b0 || d !== mem_word(a[ADDR_W-1:0]) || (cmd_count - c0) != (exp_hit ? 0 : 1) || (exp_hit && lat != 2)) begin
        n_fail++;
        $display("FAIL rand[%0d] addr %h: got done %b err %b data %h cmds %0d lat %0d expected 1 0 %h %0d hit=%b", i, a, got, e, d, cmd_count - c0, lat, mem_word(a[ADDR_W-1:0]), exp_hit ? 0 : 1, exp_hit);
      end
      model_valid = 1; model_addr = a[ADDR_W-1:0];
    end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.word_addr = '0;
    test_reset();
    test_miss();
    test_hit();
    test_held_req();
    test_timeout();
    test_reset_mid_read();
    test_sequential();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/flash_read_responder.md
Name: flash_read_responder

Overview:
- Responder end of the player's flash-read handshake. Serves level-held read requests (word address in, `done_signal` pulse plus 32-bit data out) by issuing single-word reads on the Avalon-MM flash controller port.
- Adds a one-word hit buffer and a read timeout.
- Sits between the audio playback FSM and the flash controller IP, in the clk50M domain.

Parameters:
- ADDR_W, 23, flash word-address width on the Avalon side.
- TIMEOUT_CYCLES, 1023, max cycles from accepted command to readdatavalid before an error response.
- TO_W, 10, width of the timeout counter; TIMEOUT_CYCLES must be less than 2**TO_W.

Ports:
- clk50M  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  read request level; held high by the requester until it sees done_signal.
- word_addr  in  24  requested word address; only [ADDR_W-1:0] is used; sampled in IDLE when req=1.
- done_signal  out  1  one-cycle pulse: rd_data is valid.
- rd_data  out  32  returned word; held stable until the next done_signal.
- rd_error  out  1  one-cycle pulse coincident with done_signal when the read timed out.
- flash_mem_read  out  1  Avalon read command.
- flash_mem_address  out  ADDR_W  Avalon word address.
- flash_mem_byteenable  out  4  constant 4'b1111.
- flash_mem_burstcount  out  6  constant 6'd1.
- flash_mem_waitrequest  in  1  Avalon stall.
- flash_mem_readdatavalid  in  1  Avalon read data valid.
- flash_mem_readdata  in  32  Avalon read data.

Behaviour:
- Reset values: done_signal=0, rd_error=0, rd_data=0, flash_mem_read=0, flash_mem_address=0, hit_valid=0, state=IDLE, timeout counter=0, stale=0. Reset mid-read aborts the read with no response.
- States: IDLE, ISSUE, WAIT_DATA, RESPOND, RELEASE.
- IDLE, req=1: latch addr_q = word_addr[ADDR_W-1:0].
  - If hit_valid and addr_q==hit_addr: go to RESPOND with rd_data=hit_data. Latency from req to done_signal is 2 cycles; no Avalon traffic.
  - Otherwise go to ISSUE.
- ISSUE: flash_mem_read=1, flash_mem_address=addr_q. Hold both while flash_mem_waitrequest=1. The cycle waitrequest=0 accepts the command; next state is WAIT_DATA and the timeout counter clears.
- WAIT_DATA: flash_mem_read=0. Counter increments each cycle.
  - readdatavalid=1: rd_data<=readdata, hit_addr<=addr_q, hit_data<=readdata, hit_valid<=1, then RESPOND.
  - Counter==TIMEOUT_CYCLES with no valid: rd_data<=0, set rd_error_pending, hit_valid<=0, set stale=1, then RESPOND.
  - Valid and timeout in the same cycle: valid wins, no error.
- RESPOND: done_signal=1 for exactly one cycle; rd_error=rd_error_pending, which then clears. Next state RELEASE.
- RELEASE: wait for req=0, then go to IDLE. A requester holding req one cycle after done must not trigger a second read.
- stale: a readdatavalid arriving while stale=1 is discarded (no hit update, no response) and clears stale.
  - While stale=1, IDLE does not leave to ISSUE; it waits until stale clears or TIMEOUT_CYCLES more cycles elapse. Only one Avalon read is outstanding at any time.
- readdatavalid in IDLE, ISSUE, RESPOND or RELEASE with stale=0 is ignored.
- word_addr changes while req is high after sampling are ignored.
- Address compare uses ADDR_W bits only, so the upper bits of word_addr cannot cause a false miss.
- Requester-side address (word_addr) is 24 bits; the Avalon address is truncated to ADDR_W, no wrap logic.

Decomposition:
- Package flash_rd_pkg:
  - enum rd_state_t {IDLE, ISSUE, WAIT_DATA, RESPOND, RELEASE}.
  - localparam FLASH_BE_ALL=4'b1111.
  - localparam FLASH_BURST_ONE=6'd1.
- One sub-module, flash_hit_buffer: holds hit_valid, hit_addr and hit_data, with load, invalidate and compare ports. Everything else lives in the top FSM.

Test Plan:
- Miss read: req=1, word_addr=24'h000100; waitrequest=1 for 3 cycles, then readdatavalid 4 cycles after accept with data 32'hA1B2C3D4 -> flash_mem_address=23'h000100 held during the stall, one done_signal, rd_data=32'hA1B2C3D4, rd_error=0, exactly one accepted command.
- Hit: repeat word_addr=24'h000100 after req drops -> done_signal 2 cycles after req, flash_mem_read stays 0, rd_data=32'hA1B2C3D4.
- Held req: req stays high 5 cycles past done_signal -> no second command, no second done_signal; a new req after the drop to 0 is served.
- Timeout: TIMEOUT_CYCLES=15, no readdatavalid -> done_signal with rd_error=1 and rd_data=0 exactly 16 cycles after accept. Late valid (32'hDEADBEEF) is discarded; the next req for the same address misses and reissues.
- Reset in WAIT_DATA: assert reset for 1 cycle -> no done_signal, all outputs 0, hit_valid=0; the next req reads from flash.
- Sequential playback: 8 consecutive addresses 24'h000200..24'h000207 with the requester dropping req 1 cycle after each done -> 8 commands, 8 done pulses, data in order.
